// File: rtl/i2c_reg_bank.sv
// rtl/i2c_reg_bank.sv - 32-bit control/status register bank served by the I2C slave RAM strobes
module i2c_reg_bank #(
    parameter int          NUM_RW    = 16,
    parameter logic [31:0] ID_VALUE  = 32'h4C41_0001,
    parameter logic [31:0] BAD_VALUE = 32'hDEAD_BEEF
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_n_i,
    input  logic                  ram_wr_en_i,
    input  logic [7:0]            ram_wr_addr_i,
    input  logic [31:0]           ram_wr_data_i,
    input  logic                  ram_rd_en_i,
    input  logic [7:0]            ram_rd_addr_i,
    output logic [31:0]           ram_rd_data_o,
    input  logic [31:0]           sts_set_i,
    output logic [31:0]           ctrl_o,
    output logic [NUM_RW*32-1:0]  rw_reg_o,
    output logic                  wr_strobe_o,
    output logic [7:0]            wr_strobe_addr_o,
    output logic                  irq_o
);

    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h01;
    localparam logic [7:0] ADDR_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_IRQ_MSK = 8'h03;
    localparam logic [7:0] ADDR_WR_CNT  = 8'h04;
    localparam logic [7:0] ADDR_ERR_CNT = 8'h05;
    localparam int         RW_BASE      = 16;

    logic [31:0]          ctrl;
    logic [31:0]          status;
    logic [31:0]          irq_msk;
    logic [31:0]          wr_cnt;
    logic [31:0]          err_cnt;
    logic [NUM_RW*32-1:0] rw_regs;

    logic        wr_rw_hit;
    logic        wr_accept;
    logic        wr_illegal;
    logic        rd_mapped;
    logic        rd_illegal;
    logic [31:0] rd_value;
    logic [31:0] status_clr;
    logic [1:0]  err_inc;
    logic [32:0] err_sum;
    logic [31:0] err_next;

    always_comb begin
        wr_rw_hit = 1'b0;
        for (int k = 0; k < NUM_RW; k++) begin
            if (ram_wr_addr_i == 8'(RW_BASE + k)) wr_rw_hit = 1'b1;
        end
    end

    assign wr_accept  = ram_wr_en_i && (wr_rw_hit ||
                        ram_wr_addr_i == ADDR_CTRL ||
                        ram_wr_addr_i == ADDR_STATUS ||
                        ram_wr_addr_i == ADDR_IRQ_MSK);
    assign wr_illegal = ram_wr_en_i && !wr_accept;

    // Read mux sees the pre-edge register values, so same-cycle writes/increments are not visible
    always_comb begin
        rd_value  = BAD_VALUE;
        rd_mapped = 1'b1;
        case (ram_rd_addr_i)
            ADDR_ID:      rd_value = ID_VALUE;
            ADDR_CTRL:    rd_value = ctrl;
            ADDR_STATUS:  rd_value = status;
            ADDR_IRQ_MSK: rd_value = irq_msk;
            ADDR_WR_CNT:  rd_value = wr_cnt;
            ADDR_ERR_CNT: rd_value = err_cnt;
            default: begin
                rd_mapped = 1'b0;
                for (int k = 0; k < NUM_RW; k++) begin
                    if (ram_rd_addr_i == 8'(RW_BASE + k)) begin
                        rd_value  = rw_regs[k*32 +: 32];
                        rd_mapped = 1'b1;
                    end
                end
            end
        endcase
    end

    assign rd_illegal = ram_rd_en_i && !rd_mapped;

    // An illegal read and an illegal write in one cycle add two, clamped at all-ones
    assign err_inc  = {1'b0, wr_illegal} + {1'b0, rd_illegal};
    assign err_sum  = {1'b0, err_cnt} + 33'(err_inc);
    assign err_next = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];

    assign status_clr = (ram_wr_en_i && ram_wr_addr_i == ADDR_STATUS) ? ram_wr_data_i : 32'h0;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl             <= 32'h0;
            status           <= 32'h0;
            irq_msk          <= 32'h0;
            wr_cnt           <= 32'h0;
            err_cnt          <= 32'h0;
            rw_regs          <= '0;
            ram_rd_data_o    <= 32'h0;
            wr_strobe_o      <= 1'b0;
            wr_strobe_addr_o <= 8'h0;
            irq_o            <= 1'b0;
        end else begin
            if (ram_wr_en_i && ram_wr_addr_i == ADDR_CTRL)    ctrl    <= ram_wr_data_i;
            if (ram_wr_en_i && ram_wr_addr_i == ADDR_IRQ_MSK) irq_msk <= ram_wr_data_i;
            for (int k = 0; k < NUM_RW; k++) begin
                if (ram_wr_en_i && ram_wr_addr_i == 8'(RW_BASE + k))
                    rw_regs[k*32 +: 32] <= ram_wr_data_i;
            end
            status  <= (status & ~status_clr) | sts_set_i;
            err_cnt <= err_next;
            if (wr_accept) begin
                wr_cnt           <= wr_cnt + 32'd1;
                wr_strobe_addr_o <= ram_wr_addr_i;
            end
            wr_strobe_o <= wr_accept;
            if (ram_rd_en_i) ram_rd_data_o <= rd_value;
            irq_o <= |(status & irq_msk);
        end
    end

    assign ctrl_o   = ctrl;
    assign rw_reg_o = rw_regs;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb/tb_i2c_reg_bank.sv - directed self-checking bench for i2c_reg_bank
module tb_i2c_reg_bank;

    localparam int NUM_RW = 16;

    logic                 sys_clk_i = 1'b0;
    logic                 rst_n_i;
    logic                 ram_wr_en_i;
    logic [7:0]           ram_wr_addr_i;
    logic [31:0]          ram_wr_data_i;
    logic                 ram_rd_en_i;
    logic [7:0]           ram_rd_addr_i;
    logic [31:0]          ram_rd_data_o;
    logic [31:0]          sts_set_i;
    logic [31:0]          ctrl_o;
    logic [NUM_RW*32-1:0] rw_reg_o;
    logic                 wr_strobe_o;
    logic [7:0]           wr_strobe_addr_o;
    logic                 irq_o;

    int n_checks = 0;
    int n_pass   = 0;

    i2c_reg_bank #(.NUM_RW(NUM_RW)) dut (
        .sys_clk_i        (sys_clk_i),
        .rst_n_i          (rst_n_i),
        .ram_wr_en_i      (ram_wr_en_i),
        .ram_wr_addr_i    (ram_wr_addr_i),
        .ram_wr_data_i    (ram_wr_data_i),
        .ram_rd_en_i      (ram_rd_en_i),
        .ram_rd_addr_i    (ram_rd_addr_i),
        .ram_rd_data_o    (ram_rd_data_o),
        .sts_set_i        (sts_set_i),
        .ctrl_o           (ctrl_o),
        .rw_reg_o         (rw_reg_o),
        .wr_strobe_o      (wr_strobe_o),
        .wr_strobe_addr_o (wr_strobe_addr_o),
        .irq_o            (irq_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // One bus cycle: drive at negedge, let one posedge pass, clear, land on the next negedge
    task automatic bus_cycle(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                             input logic re, input logic [7:0] ra, input logic [31:0] sts);
        ram_wr_en_i   = we;
        ram_wr_addr_i = wa;
        ram_wr_data_i = wd;
        ram_rd_en_i   = re;
        ram_rd_addr_i = ra;
        sts_set_i     = sts;
        @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        ram_wr_en_i = 1'b0;
        ram_rd_en_i = 1'b0;
        sts_set_i   = 32'h0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus_cycle(1'b1, a, d, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic rd(input logic [7:0] a);
        bus_cycle(1'b0, 8'h00, 32'h0, 1'b1, a, 32'h0);
    endtask

    task automatic idle();
        bus_cycle(1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        ram_wr_en_i = 1'b0; ram_wr_addr_i = 8'h0; ram_wr_data_i = 32'h0;
        ram_rd_en_i = 1'b0; ram_rd_addr_i = 8'h0; sts_set_i = 32'h0;
        repeat (2) @(negedge sys_clk_i);
        check_eq("reset_rd_data", ram_rd_data_o, 32'h0);
        check_eq("reset_ctrl", ctrl_o, 32'h0);
        check_eq("reset_irq", {31'h0, irq_o}, 32'h0);
        check_eq("reset_strobe", {31'h0, wr_strobe_o}, 32'h0);
        rst_n_i = 1'b1;
        @(negedge sys_clk_i);

        // ID read: still 0 before the edge, ID after it
        ram_rd_en_i = 1'b1; ram_rd_addr_i = 8'h00;
        #1 check_eq("id_before_edge", ram_rd_data_o, 32'h0);
        @(posedge sys_clk_i); @(negedge sys_clk_i);
        ram_rd_en_i = 1'b0;
        check_eq("id_read", ram_rd_data_o, 32'h4C41_0001);
        idle();
        check_eq("rd_data_held", ram_rd_data_o, 32'h4C41_0001);

        wr(8'h01, 32'h1234_5678);
        check_eq("ctrl_o", ctrl_o, 32'h1234_5678);
        check_eq("strobe_ctrl", {31'h0, wr_strobe_o}, 32'h1);
        check_eq("strobe_addr_ctrl", {24'h0, wr_strobe_addr_o}, 32'h01);
        rd(8'h01);
        check_eq("strobe_one_cycle", {31'h0, wr_strobe_o}, 32'h0);
        check_eq("ctrl_read", ram_rd_data_o, 32'h1234_5678);
        rd(8'h04);
        check_eq("wr_cnt_1", ram_rd_data_o, 32'd1);

        // Sticky status and masked interrupt with 1-cycle lag
        bus_cycle(1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0000_0008);
        wr(8'h03, 32'h0000_0008);
        check_eq("irq_lag", {31'h0, irq_o}, 32'h0);
        idle();
        check_eq("irq_set", {31'h0, irq_o}, 32'h1);
        bus_cycle(1'b1, 8'h02, 32'h0000_0008, 1'b0, 8'h00, 32'h0000_0008);
        rd(8'h02);
        check_eq("status_set_wins", ram_rd_data_o, 32'h0000_0008);
        check_eq("irq_still_set", {31'h0, irq_o}, 32'h1);
        wr(8'h02, 32'h0000_0008);
        check_eq("irq_clear_lag", {31'h0, irq_o}, 32'h1);
        idle();
        check_eq("irq_cleared", {31'h0, irq_o}, 32'h0);
        rd(8'h02);
        check_eq("status_cleared", ram_rd_data_o, 32'h0);

        // Illegal write to ID together with unmapped read: ERR_CNT +2
        bus_cycle(1'b1, 8'h00, 32'hFFFF_0000, 1'b1, 8'h40, 32'h0);
        check_eq("bad_read", ram_rd_data_o, 32'hDEAD_BEEF);
        check_eq("no_strobe_illegal", {31'h0, wr_strobe_o}, 32'h0);
        rd(8'h00);
        check_eq("id_unchanged", ram_rd_data_o, 32'h4C41_0001);
        rd(8'h05);
        check_eq("err_cnt_2", ram_rd_data_o, 32'd2);
        rd(8'h04);
        check_eq("wr_cnt_4", ram_rd_data_o, 32'd4);

        // Same-address read/write returns the old value
        bus_cycle(1'b1, 8'h1F, 32'hA5A5_A5A5, 1'b1, 8'h1F, 32'h0);
        check_eq("rw15_pre_write", ram_rd_data_o, 32'h0);
        check_eq("strobe_addr_rw15", {24'h0, wr_strobe_addr_o}, 32'h1F);
        rd(8'h1F);
        check_eq("rw15_read", ram_rd_data_o, 32'hA5A5_A5A5);
        check_eq("rw15_port", rw_reg_o[511:480], 32'hA5A5_A5A5);
        check_eq("rw0_port", rw_reg_o[31:0], 32'h0);

        // Counter wrap and saturation
        force dut.wr_cnt  = 32'hFFFF_FFFF;
        force dut.err_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt;
        release dut.err_cnt;
        wr(8'h10, 32'h0000_0055);
        wr(8'h05, 32'h0000_0001);
        rd(8'h04);
        check_eq("wr_cnt_wrap", ram_rd_data_o, 32'h0);
        rd(8'h05);
        check_eq("err_cnt_sat", ram_rd_data_o, 32'hFFFF_FFFF);

        // Reset in the middle of a write: no update, no strobe
        ram_wr_en_i = 1'b1; ram_wr_addr_i = 8'h01; ram_wr_data_i = 32'hCAFE_F00D;
        rst_n_i = 1'b0;
        #1 check_eq("rst_ctrl", ctrl_o, 32'h0);
        @(posedge sys_clk_i); @(negedge sys_clk_i);
        ram_wr_en_i = 1'b0;
        rst_n_i = 1'b1;
        @(negedge sys_clk_i);
        check_eq("rst_no_strobe", {31'h0, wr_strobe_o}, 32'h0);
        check_eq("rst_ctrl_after", ctrl_o, 32'h0);
        check_eq("rst_rw15", rw_reg_o[511:480], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
